// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory bus bundle between the IF/MEM stages, the shared memory
// and mem_port_arbiter. The arbiter takes the slave modport; the CPU/memory side takes master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise data wins ties.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;

  logic        if_elig, d_elig, d_wins_tie, grant_d, grant_if;

  // A request whose ack is high this cycle is being released, so it may not be re-granted.
  assign if_elig = bus.if_req & ~if_ack_q;
  assign d_elig  = bus.d_req & ~d_ack_q;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;
  assign d_wins_tie = ~last_d_q;
`else
  assign d_wins_tie = 1'b1;
`endif

  assign grant_d  = d_elig & (~if_elig | d_wins_tie);
  assign grant_if = if_elig & ~grant_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_ACC;
          cnt_d       = 3'(MEM_LAT - 1);
          mem_en_d    = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr & ~32'h3;
          mem_wdata_d = bus.d_wdata;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (grant_if) begin
          state_d     = IF_ACC;
          cnt_d       = 3'(MEM_LAT - 1);
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr & ~32'h3;
          mem_wdata_d = 32'h0;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end
      IF_ACC, D_ACC: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Last busy cycle: memory data is valid now, ack lands next cycle back in IDLE.
          if (state_q == IF_ACC) begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end else begin
            if (!mem_we_q) d_rdata_d = bus.mem_rdata;
            d_ack_d = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Pointer resets to "last winner = IF" so data takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`endif

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2; "cycle n" is the window
// starting 1 time unit after the n-th rising edge of an access.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    #1;
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_acks", {30'h0, bus.if_ack, bus.d_ack}, 32'h0);
    tick(); tick();
    rst = 0;
    tick();

    // Lone fetch
    bus.if_req = 1; bus.if_addr = 32'h0000_0013; bus.mem_rdata = 32'h2002_0005;
    #1;
    chk("fetch_c0_stall_if", 32'(bus.stall_if), 32'h1);
    chk("fetch_c0_mem_en", 32'(bus.mem_en), 32'h0);
    tick();
    chk("fetch_c1_mem_en", 32'(bus.mem_en), 32'h1);
    chk("fetch_c1_mem_addr", bus.mem_addr, 32'h0000_0010);
    chk("fetch_c1_stall_if", 32'(bus.stall_if), 32'h1);
    tick();
    chk("fetch_c2_mem_en", 32'(bus.mem_en), 32'h1);
    chk("fetch_c2_stall_if", 32'(bus.stall_if), 32'h1);
    chk("fetch_c2_if_ack", 32'(bus.if_ack), 32'h0);
    tick();
    chk("fetch_c3_if_ack", 32'(bus.if_ack), 32'h1);
    chk("fetch_c3_if_rdata", bus.if_rdata, 32'h2002_0005);
    chk("fetch_c3_stall_if", 32'(bus.stall_if), 32'h0);
    chk("fetch_c3_mem_en", 32'(bus.mem_en), 32'h0);
    bus.if_req = 0;
    tick();
    chk("fetch_c4_if_ack", 32'(bus.if_ack), 32'h0);
    chk("fetch_c4_mem_en", 32'(bus.mem_en), 32'h0);

    // Collision: data load wins, fetch follows
    bus.if_req = 1; bus.if_addr = 32'h0000_0024;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0080; bus.mem_rdata = 32'h1111_2222;
    tick();
    chk("coll_c1_mem_addr", bus.mem_addr, 32'h0000_0080);
    chk("coll_c1_mem_we", 32'(bus.mem_we), 32'h0);
    tick();
    chk("coll_c2_stall_mem", 32'(bus.stall_mem), 32'h1);
    tick();
    chk("coll_c3_d_ack", 32'(bus.d_ack), 32'h1);
    chk("coll_c3_d_rdata", bus.d_rdata, 32'h1111_2222);
    chk("coll_c3_stall_mem", 32'(bus.stall_mem), 32'h0);
    chk("coll_c3_stall_if", 32'(bus.stall_if), 32'h1);
    chk("coll_c3_if_rdata_held", bus.if_rdata, 32'h2002_0005);
    bus.d_req = 0; bus.mem_rdata = 32'h3333_4444;
    tick();
    chk("coll_c4_mem_en", 32'(bus.mem_en), 32'h1);
    chk("coll_c4_mem_addr", bus.mem_addr, 32'h0000_0024);
    tick();
    chk("coll_c5_stall_if", 32'(bus.stall_if), 32'h1);
    chk("coll_c5_mem_en", 32'(bus.mem_en), 32'h1);
    tick();
    chk("coll_c6_if_ack", 32'(bus.if_ack), 32'h1);
    chk("coll_c6_if_rdata", bus.if_rdata, 32'h3333_4444);
    chk("coll_c6_stall_if", 32'(bus.stall_if), 32'h0);
    bus.if_req = 0;
    tick();

    // Lone store leaves d_rdata untouched
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0000_0040;
    bus.d_wdata = 32'hDEAD_BEEF; bus.mem_rdata = 32'h5555_AAAA;
    tick();
    chk("st_c1_mem_we", 32'(bus.mem_we), 32'h1);
    chk("st_c1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_c1_mem_addr", bus.mem_addr, 32'h0000_0040);
    tick();
    chk("st_c2_mem_we", 32'(bus.mem_we), 32'h1);
    chk("st_c2_d_ack", 32'(bus.d_ack), 32'h0);
    tick();
    chk("st_c3_d_ack", 32'(bus.d_ack), 32'h1);
    chk("st_c3_d_rdata", bus.d_rdata, 32'h1111_2222);
    chk("st_c3_mem_we", 32'(bus.mem_we), 32'h0);
    bus.d_req = 0; bus.d_we = 0;
    tick();

    // Both held continuously: grants alternate D, IF, D, IF
    bus.if_req = 1; bus.if_addr = 32'h0000_0200;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rdata = 32'hA000_0000 + 32'(k);
      tick();
      chk($sformatf("alt%0d_mem_addr", k), bus.mem_addr,
          (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      tick();
      tick();
      chk($sformatf("alt%0d_acks", k), {30'h0, bus.if_ack, bus.d_ack},
          (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3) begin
        bus.if_req = 0; bus.d_req = 0;
      end
    end
    chk("alt_d_rdata", bus.d_rdata, 32'hA000_0002);
    chk("alt_if_rdata", bus.if_rdata, 32'hA000_0003);
    tick();
    chk("alt_end_mem_en", 32'(bus.mem_en), 32'h0);

    // Ack-cycle release: d_req held into the ack cycle must not be re-granted
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0044; bus.mem_rdata = 32'h6666_0000;
    tick(); tick(); tick();
    chk("rel_c3_d_ack", 32'(bus.d_ack), 32'h1);
    chk("rel_c3_d_rdata", bus.d_rdata, 32'h6666_0000);
    tick();
    chk("rel_c4_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rel_c4_d_ack", 32'(bus.d_ack), 32'h0);
    bus.d_req = 0;
    tick();
    chk("rel_c5_mem_en", 32'(bus.mem_en), 32'h0);

    // Reset mid-access
    bus.if_req = 1; bus.if_addr = 32'h0000_0030; bus.mem_rdata = 32'h7777_8888;
    tick();
    chk("rstm_c1_mem_en", 32'(bus.mem_en), 32'h1);
    rst = 1;
    #1;
    chk("rstm_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rstm_mem_addr", bus.mem_addr, 32'h0);
    chk("rstm_if_rdata", bus.if_rdata, 32'h0);
    chk("rstm_d_rdata", bus.d_rdata, 32'h0);
    tick();
    chk("rstm_c2_if_ack", 32'(bus.if_ack), 32'h0);
    rst = 0;
    tick();
    chk("rstm_r1_mem_en", 32'(bus.mem_en), 32'h1);
    chk("rstm_r1_mem_addr", bus.mem_addr, 32'h0000_0030);
    tick();
    chk("rstm_r2_if_ack", 32'(bus.if_ack), 32'h0);
    tick();
    chk("rstm_r3_if_ack", 32'(bus.if_ack), 32'h1);
    chk("rstm_r3_if_rdata", bus.if_rdata, 32'h7777_8888);
    bus.if_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the pipelined CPU. Sequences each multi-cycle memory access with a small FSM and a latency counter. Returns read data with a one-cycle acknowledge. Drives per-stage stall signals that freeze the PC/IR (IF) or the MEM stage until its access completes.

## Interface
- `MEM_LAT`, default 2: memory busy cycles per access; legal values 1..7.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `if_req`  in  1  fetch request, level; held until `if_ack`.
- `if_addr`  in  32  fetch byte address; stable while `if_req`.
- `if_rdata`  out  32  fetched instruction; valid while `if_ack`=1.
- `if_ack`  out  1  one-cycle fetch-complete pulse.
- `d_req`  in  1  data request, level; held until `d_ack`.
- `d_we`  in  1  1 = store (sw), 0 = load (lw).
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_rdata`  out  32  load data; valid while `d_ack`=1.
- `d_ack`  out  1  one-cycle data-complete pulse.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  memory byte address, bits [1:0] forced to 0.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid in the last busy cycle.
- `stall_if`  out  1  `if_req & ~if_ack` (combinational).
- `stall_mem`  out  1  `d_req & ~d_ack` (combinational).

## Operation
- FSM states: IDLE, IF_ACC, D_ACC.
- Eligibility in IDLE: a request is eligible only when its ack is low in that cycle. This prevents re-granting a request that is being released.
- IDLE arbitration:
  - If only one requester is eligible, grant it.
  - If both are eligible, data wins (fixed priority, see Configuration).
  - On grant, register the `mem_*` outputs from the winner (fetch: `mem_we`=0, `mem_wdata`=0). Load `cnt` with MEM_LAT-1 and enter IF_ACC or D_ACC.
- In IF_ACC and D_ACC:
  - `mem_*` outputs stay constant.
  - When `cnt`≠0, decrement `cnt`.
  - When `cnt`=0:
    - Capture `mem_rdata` into `if_rdata`, or into `d_rdata` for loads only. A store leaves `d_rdata` unchanged.
    - Assert the matching ack for the next cycle.
    - Clear `mem_en` and `mem_we`, and return to IDLE.
- Requests are never preempted. Request inputs changing mid-access are ignored until IDLE.
- `if_rdata` and `d_rdata` hold their last captured value between accesses.

## Timing
- Request first visible in cycle 0 (IDLE, eligible).
- `mem_en`=1 in cycles 1..MEM_LAT.
- `mem_rdata` is sampled at the end of cycle MEM_LAT.
- Ack and rdata are valid in cycle MEM_LAT+1; the FSM is back in IDLE in that same cycle.
- Throughput: one access per MEM_LAT+1 cycles. Back-to-back grants are possible because the other requester is eligible in the ack cycle.
- Stall duration: a lone request stalls for MEM_LAT+1 cycles. A losing request additionally waits for the winner's full access.
- Reset values: state IDLE, `cnt`=0, and every registered output 0 (`mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata`, `if_ack`, `d_ack`, round-robin pointer).
- Reset mid-access: the access aborts immediately (asynchronous), no ack is issued, and the requester re-arbitrates after reset.
- MEM_LAT=1: `cnt` is loaded with 0, giving exactly one busy cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: when both requesters are eligible in IDLE, the grant alternates. A 1-bit pointer records the last winner and the other requester wins next. The pointer resets to "last = IF", so data wins the first tie. A lone request never changes pointer semantics: the pointer always records the actual winner.
- `MEM_ARB_RR_EN` undefined: data always wins ties (fixed priority) and no pointer exists.

## Test plan
All scenarios use MEM_LAT=2.
- Lone fetch: `if_req`=1 with `if_addr`=0x0000_0013 at cycle 0; memory returns 0x2002_0005.
  - `mem_en` high in cycles 1–2 with `mem_addr`=0x0000_0010.
  - `if_ack`=1 and `if_rdata`=0x2002_0005 in cycle 3.
  - `stall_if` high in cycles 0–2.
- Lone store: `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEAD_BEEF.
  - `mem_we`=1 in cycles 1–2.
  - `d_ack` in cycle 3.
  - `d_rdata` unchanged.
- Collision, fixed priority: `if_req` and `d_req` (load 0x80) both raised at cycle 0.
  - `d_ack` in cycle 3.
  - IF is granted in cycle 3, with `mem_en` in cycles 4–5 and `if_ack` in cycle 6.
  - `stall_if` high in cycles 0–5.
- Round-robin (`MEM_ARB_RR_EN` defined): both requests held continuously for 4 accesses.
  - Grant order is D, IF, D, IF.
  - Acks in cycles 3, 6, 9, 12.
- Reset mid-access: assert `rst` in cycle 1 of a fetch.
  - `mem_en` and all outputs drop to 0 the same cycle.
  - No `if_ack`.
  - After release, the held `if_req` completes normally, with ack MEM_LAT+1 cycles after the first IDLE cycle.
- Ack-cycle release: `d_req` held one cycle past `d_ack`, with no fetch pending.
  - No second data grant occurs in the ack cycle.
  - A new grant occurs in the following cycle only if `d_req` is still high.
